// File: rtl/rv32im_muldiv_unit.sv
// rv32im_muldiv_unit: multi-cycle RV32M multiply/divide unit beside the EX-stage ALU.
// Single-cycle multiply, restoring divide (1 bit/cycle), registered result with a one-cycle valid pulse.
module rv32im_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  input  logic [6:0]       i_opcode,
  input  logic [2:0]       i_funct3,
  input  logic [6:0]       i_funct7,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  input  logic             i_flush,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rem;
  logic [CW-1:0]    r_cnt;
  logic             r_negq;
  logic             r_negr;
  logic [WIDTH-1:0] r_result;

  logic                 w_accept;
  logic                 w_sa;
  logic                 w_sb;
  logic                 w_div0;
  logic                 w_ovf;
  logic [WIDTH-1:0]     w_spec_res;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic signed [WIDTH:0] w_ae;
  logic signed [WIDTH:0] w_be;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH:0]       w_sh;
  logic [WIDTH:0]       w_sub;
  logic [WIDTH-1:0]     w_q;
  logic [WIDTH-1:0]     w_r;
  logic [WIDTH-1:0]     w_div_res;

  assign w_accept = i_valid & (r_state == S_IDLE) & (i_opcode == 7'b0110011) & (i_funct7 == 7'b0000001);

  // Signed divide ops (DIV/REM) have funct3[0]==0.
  assign w_div0     = (i_rs2_data == '0);
  assign w_ovf      = ~i_funct3[0] & (i_rs1_data == {1'b1, {(WIDTH-1){1'b0}}}) & (&i_rs2_data);
  assign w_spec_res = w_div0 ? (i_funct3[1] ? i_rs1_data : '1) : (i_funct3[1] ? '0 : i_rs1_data);
  assign w_abs_a    = (~i_funct3[0] & i_rs1_data[WIDTH-1]) ? -i_rs1_data : i_rs1_data;
  assign w_abs_b    = (~i_funct3[0] & i_rs2_data[WIDTH-1]) ? -i_rs2_data : i_rs2_data;

  // MULH/MULHSU sign-extend A; only MULH sign-extends B.
  assign w_sa   = (r_op[1:0] == 2'b01) | (r_op[1:0] == 2'b10);
  assign w_sb   = (r_op[1:0] == 2'b01);
  assign w_ae   = {w_sa & r_a[WIDTH-1], r_a};
  assign w_be   = {w_sb & r_b[WIDTH-1], r_b};
  assign w_prod = (2*WIDTH)'(w_ae * w_be);

  assign w_sh      = {r_rem, r_a[WIDTH-1]};
  assign w_sub     = w_sh - {1'b0, r_b};
  assign w_q       = {r_a[WIDTH-2:0], ~w_sub[WIDTH]};
  assign w_r       = w_sub[WIDTH] ? w_sh[WIDTH-1:0] : w_sub[WIDTH-1:0];
  assign w_div_res = r_op[1] ? (r_negr ? -w_r : w_r) : (r_negq ? -w_q : w_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_negq   <= 1'b0;
      r_negr   <= 1'b0;
      r_result <= '0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_op <= i_funct3;
          if (!i_funct3[2]) begin
            r_a     <= i_rs1_data;
            r_b     <= i_rs2_data;
            r_state <= S_MUL;
          end else if (w_div0 | w_ovf) begin
            r_result <= w_spec_res;
            r_state  <= S_DONE;
          end else begin
            r_a     <= w_abs_a;
            r_b     <= w_abs_b;
            r_rem   <= '0;
            r_cnt   <= CW'(WIDTH-1);
            r_negq  <= ~i_funct3[0] & (i_rs1_data[WIDTH-1] ^ i_rs2_data[WIDTH-1]);
            r_negr  <= ~i_funct3[0] & i_rs1_data[WIDTH-1];
            r_state <= S_DIV;
          end
        end
        S_MUL: begin
          r_result <= (r_op[1:0] == 2'b00) ? w_prod[WIDTH-1:0] : w_prod[2*WIDTH-1:WIDTH];
          r_state  <= S_DONE;
        end
        S_DIV: begin
          r_a   <= w_q;
          r_rem <= w_r;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_result <= w_div_res;
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ready  = (r_state == S_IDLE);
  assign o_busy   = (r_state == S_MUL) | (r_state == S_DIV);
  assign o_valid  = (r_state == S_DONE);
  assign o_result = r_result;
endmodule

// File: tb/tb_rv32im_muldiv_unit.sv
// tb_rv32im_muldiv_unit: directed vectors into a scoreboard queue; a negedge monitor checks
// every o_valid against the queued result and its expected arrival edge.
module tb_rv32im_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [6:0]  i_opcode = 7'b0110011;
  logic [2:0]  i_funct3 = '0;
  logic [6:0]  i_funct7 = 7'b0000001;
  logic [31:0] i_rs1_data = '0;
  logic [31:0] i_rs2_data = '0;
  logic        i_flush = 1'b0;
  logic        o_ready, o_busy, o_valid;
  logic [31:0] o_result;

  typedef struct {logic [31:0] r; int c;} exp_t;
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  rv32im_muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_opcode(i_opcode), .i_funct3(i_funct3),
    .i_funct7(i_funct7), .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_flush(i_flush),
    .o_ready(o_ready), .o_busy(o_busy), .o_valid(o_valid), .o_result(o_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && o_busy) busy_cnt++;
    if (rst_n && o_valid) begin
      if (sb.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", o_result, e.r);
        chk("latency_edge", cyc, e.c);
      end
    end
  end

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    i_valid = 1'b1; i_opcode = 7'b0110011; i_funct7 = 7'b0000001;
    i_funct3 = f3; i_rs1_data = a; i_rs2_data = b;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, o_ready}, 32'd1);
  endtask

  task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat, input int bexp);
    @(negedge clk);
    chk({name, "_ready"}, {31'd0, o_ready}, 32'd1);
    drive(f3, a, b);
    sb.push_back('{exp, cyc + lat});
    busy_cnt = 0;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    i_rs1_data = $urandom; i_rs2_data = $urandom; i_funct3 = 3'($urandom);
    @(negedge clk);
    wait_idle({name, "_idle"});
    chk({name, "_busy_cycles"}, busy_cnt, bexp);
    chk({name, "_hold"}, o_result, exp);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_result", o_result, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);

    issue("mul_neg",   3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2, 1);
    issue("mul_pos",   3'b000, 32'd12345,    32'd1000,     32'h00BC5EA8, 2, 1);
    issue("mulh",      3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 2, 1);
    issue("mulhu",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2, 1);
    issue("mulhsu",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 1);
    issue("div_neg",   3'b100, -32'd20,      32'd3,        32'hFFFFFFFA, 33, 32);
    issue("rem_neg",   3'b110, -32'd20,      32'd3,        32'hFFFFFFFE, 33, 32);
    issue("div_negb",  3'b100, 32'd20,       -32'd3,       32'hFFFFFFFA, 33, 32);
    issue("rem_negb",  3'b110, 32'd20,       -32'd3,       32'd2,        33, 32);
    issue("divu",      3'b101, 32'd100,      32'd7,        32'd14,       33, 32);
    issue("remu",      3'b111, 32'd100,      32'd7,        32'd2,        33, 32);
    issue("divu_big",  3'b101, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 33, 32);
    issue("divu_mn",   3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33, 32);
    issue("remu_mn",   3'b111, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33, 32);
    issue("divu_z",    3'b101, 32'd100,      32'd0,        32'hFFFFFFFF, 1, 0);
    issue("remu_z",    3'b111, 32'd100,      32'd0,        32'd100,      1, 0);
    issue("div_z",     3'b100, -32'd5,       32'd0,        32'hFFFFFFFF, 1, 0);
    issue("rem_z",     3'b110, -32'd5,       32'd0,        32'hFFFFFFFB, 1, 0);
    issue("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
    issue("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1, 0);

    // Flush at iteration 10 of a divide: back to IDLE next edge, result untouched.
    @(negedge clk);
    drive(3'b100, 32'd1000, 32'd7);
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (10) @(negedge clk);
    i_flush = 1'b1;
    @(posedge clk);
    #1 i_flush = 1'b0;
    chk("flush_ready", {31'd0, o_ready}, 32'd1);
    chk("flush_busy", {31'd0, o_busy}, 32'd0);
    chk("flush_result", o_result, 32'd0);

    // Flush and request together: request is dropped.
    @(negedge clk);
    drive(3'b000, 32'd3, 32'd4);
    i_flush = 1'b1;
    @(posedge clk);
    #1 begin i_flush = 1'b0; i_valid = 1'b0; end
    chk("flush_req_ready", {31'd0, o_ready}, 32'd1);
    chk("flush_req_busy", {31'd0, o_busy}, 32'd0);

    // Plain R-type and non-OP opcodes are left to the ALU.
    @(negedge clk);
    drive(3'b000, 32'd3, 32'd4);
    i_funct7 = 7'b0000000;
    @(posedge clk);
    #1 i_valid = 1'b0;
    chk("rtype_ready", {31'd0, o_ready}, 32'd1);
    chk("rtype_busy", {31'd0, o_busy}, 32'd0);
    @(negedge clk);
    drive(3'b100, 32'd9, 32'd3);
    i_opcode = 7'b0010011;
    @(posedge clk);
    #1 i_valid = 1'b0;
    chk("opc_ready", {31'd0, o_ready}, 32'd1);
    repeat (4) @(negedge clk);

    issue("mul_after", 3'b000, 32'd6, 32'd7, 32'd42, 2, 1);

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    drive(3'b101, 32'd500, 32'd3);
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, o_busy}, 32'd0);
    chk("arst_valid", {31'd0, o_valid}, 32'd0);
    chk("arst_result", o_result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    issue("rem_final", 3'b110, -32'd7, 32'd2, 32'hFFFFFFFF, 33, 32);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
